phase_seq: RTL

//  Multi-cycle phase sequencer for the SIMPLE CPU datapath. Steps each instruction through
//  P1 fetch, P2 decode, P3 execute, P4 memory and P5 writeback. Issues phase enables and

---
 rtl/phase_seq_if.sv | 30 +++
 rtl/phase_seq.sv | 95 +++++++++
 2 files changed

// File: rtl/phase_seq_if.sv
// Handshake and control bundle between the phase sequencer and the CPU datapath.
interface phase_seq_if #(
   parameter int CNT_W = 16
);
   logic             start;
   logic             step_mode;
   logic             step;
   logic             halt_n;
   logic             mem_op;
   logic             mem_ack;
   logic             mem_req;
   logic [4:0]       phase;
   logic             ir_we;
   logic             pc_we;
   logic             wb_en;
   logic             busy;
   logic             halted;
   logic             err;
   logic [CNT_W-1:0] instr_count;

   modport master (
      output start, step_mode, step, halt_n, mem_op, mem_ack,
      input  mem_req, phase, ir_we, pc_we, wb_en, busy, halted, err, instr_count
   );

   modport slave (
      input  start, step_mode, step, halt_n, mem_op, mem_ack,
      output mem_req, phase, ir_we, pc_we, wb_en, busy, halted, err, instr_count
   );
endinterface

// File: rtl/phase_seq.sv
// Multi-cycle phase sequencer: fetch, decode, execute, memory, writeback.
//
// state  | meaning
// IDLE   | waiting for start
// P1     | fetch, mem_req held until mem_ack (IR loads on ack)
// P2     | decode, single cycle
// P3     | execute, HLT check, memory-op flag latched
// P4     | memory access if latched mem_op, else single pass-through cycle
// P5     | writeback, PC update, retired count +1
// PAUSE  | single-step hold between instructions
// HALTED | HLT retired or memory timeout; only rst leaves
module phase_seq #(
   parameter int CNT_W  = 16,
   parameter int MEM_TO = 255
) (
   input logic       clk,
   input logic       rst,
   phase_seq_if.slave bus
);
   typedef enum logic [2:0] {
      IDLE, P1, P2, P3, P4, P5, PAUSE, HALTED
   } state_t;

   localparam int WAIT_W = (MEM_TO < 2) ? 1 : $clog2(MEM_TO + 1);
   // Last count value before a timeout; if no ack arrives in that cycle the request expires.
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TO - 1);

   state_t            state;
   logic [WAIT_W-1:0] wait_cnt;
   logic              mem_op_q;
   logic              err_q;
   logic [CNT_W-1:0]  count;
   logic              req;

   assign req             = (state == P1) || ((state == P4) && mem_op_q);
   assign bus.mem_req     = req;
   assign bus.phase       = {state == P5, state == P4, state == P3, state == P2, state == P1};
   assign bus.busy        = (state == P1) || (state == P2) || (state == P3) ||
                            (state == P4) || (state == P5);
   assign bus.halted      = (state == HALTED);
   assign bus.pc_we       = (state == P5);
   assign bus.wb_en       = (state == P5);
   assign bus.ir_we       = (state == P1) && bus.mem_ack;
   assign bus.err         = err_q;
   assign bus.instr_count = count;

   // Phase sequencing, memory wait timeout and retired-instruction counting.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         wait_cnt <= '0;
         mem_op_q <= 1'b0;
         err_q    <= 1'b0;
         count    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) state <= P1;
            end
            P1, P4: begin
               if (!req) begin
                  state <= P5;
               end else if (bus.mem_ack) begin
                  wait_cnt <= '0;
                  state    <= (state == P1) ? P2 : P5;
               end else if (wait_cnt == WAIT_LAST) begin
                  wait_cnt <= '0;
                  err_q    <= 1'b1;
                  state    <= HALTED;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            P2: state <= P3;
            P3: begin
               if (!bus.halt_n) begin
                  state <= HALTED;
               end else begin
                  mem_op_q <= bus.mem_op;
                  state    <= P4;
               end
            end
            P5: begin
               count <= count + 1'b1;
               state <= bus.step_mode ? PAUSE : P1;
            end
            PAUSE: begin
               if (bus.step || !bus.step_mode) state <= P1;
            end
            HALTED: state <= HALTED;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
